// File: rtl/jtag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_pkg                                                           |
// | TAP state mirror encoding, controller phases, default dimensions.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package jtag_pkg;

    localparam int c_n_default    = 16;
    localparam int c_ir_w_default = 4;
    localparam int c_div_default  = 2;

    typedef enum logic [3:0] {
        TAP_TLR    = 4'h0,
        TAP_RTI    = 4'h1,
        TAP_SEL_DR = 4'h2,
        TAP_CAP_DR = 4'h3,
        TAP_SH_DR  = 4'h4,
        TAP_EX1_DR = 4'h5,
        TAP_PAU_DR = 4'h6,
        TAP_EX2_DR = 4'h7,
        TAP_UPD_DR = 4'h8,
        TAP_SEL_IR = 4'h9,
        TAP_CAP_IR = 4'hA,
        TAP_SH_IR  = 4'hB,
        TAP_EX1_IR = 4'hC,
        TAP_PAU_IR = 4'hD,
        TAP_EX2_IR = 4'hE,
        TAP_UPD_IR = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_PRE  = 2'd1,
        CTL_SCAN = 2'd2,
        CTL_END  = 2'd3
    } ctl_state_t;

    // IEEE 1149.1 TAP controller transition on a TCK rising edge.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:    if (tms) n = TAP_TLR;    else n = TAP_RTI;
            TAP_RTI:    if (tms) n = TAP_SEL_DR; else n = TAP_RTI;
            TAP_SEL_DR: if (tms) n = TAP_SEL_IR; else n = TAP_CAP_DR;
            TAP_CAP_DR: if (tms) n = TAP_EX1_DR; else n = TAP_SH_DR;
            TAP_SH_DR:  if (tms) n = TAP_EX1_DR; else n = TAP_SH_DR;
            TAP_EX1_DR: if (tms) n = TAP_UPD_DR; else n = TAP_PAU_DR;
            TAP_PAU_DR: if (tms) n = TAP_EX2_DR; else n = TAP_PAU_DR;
            TAP_EX2_DR: if (tms) n = TAP_UPD_DR; else n = TAP_SH_DR;
            TAP_UPD_DR: if (tms) n = TAP_SEL_DR; else n = TAP_RTI;
            TAP_SEL_IR: if (tms) n = TAP_TLR;    else n = TAP_CAP_IR;
            TAP_CAP_IR: if (tms) n = TAP_EX1_IR; else n = TAP_SH_IR;
            TAP_SH_IR:  if (tms) n = TAP_EX1_IR; else n = TAP_SH_IR;
            TAP_EX1_IR: if (tms) n = TAP_UPD_IR; else n = TAP_PAU_IR;
            TAP_PAU_IR: if (tms) n = TAP_EX2_IR; else n = TAP_PAU_IR;
            TAP_EX2_IR: if (tms) n = TAP_UPD_IR; else n = TAP_SH_IR;
            TAP_UPD_IR: if (tms) n = TAP_SEL_DR; else n = TAP_RTI;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_tck_gen                                                       |
// | TCK divider: DIV clk per half-period, idle low, rise/fall strobes. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtag_tck_gen
    import jtag_pkg::*;
#(
    parameter int DIV = c_div_default
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tck,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;
    logic            r_tck;
    logic            w_wrap;

    // Strobes fire in the cycle before TCK toggles so the consumer updates on the same edge.
    assign w_wrap = i_en && (r_cnt == c_last);
    assign o_rise = w_wrap && !r_tck;
    assign o_fall = w_wrap && r_tck;
    assign o_tck  = r_tck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_tck <= !r_tck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_bscan_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtag_bscan_master                                                  |
// | Bit-banged JTAG master: optional TLR preamble, IR scan, DR scan.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jtag_bscan_master
    import jtag_pkg::*;
#(
    parameter int N    = c_n_default,
    parameter int DR_W = 3*N+3,
    parameter int IR_W = c_ir_w_default,
    parameter int DIV  = c_div_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            tap_reset,
    input  logic [IR_W-1:0] ir_in,
    input  logic [DR_W-1:0] dr_in,
    output logic            busy,
    output logic            done,
    output logic [IR_W-1:0] ir_out,
    output logic [DR_W-1:0] dr_out,
    output logic            TCK,
    output logic            TMS,
    output logic            TDI,
    input  logic            TDO
);

    localparam int c_len = (DR_W > IR_W) ? DR_W : IR_W;
    localparam int c_cw  = $clog2(((c_len > 6) ? c_len : 6) + 1);
    localparam logic [c_cw-1:0] c_ir_last  = c_cw'(IR_W - 1);
    localparam logic [c_cw-1:0] c_dr_last  = c_cw'(DR_W - 1);
    localparam logic [c_cw-1:0] c_pre_last = c_cw'(5);

    ctl_state_t      r_ctl;
    tap_state_t      r_tap;
    logic [c_cw-1:0] r_cnt;
    logic            r_pre_req;
    logic            r_ir_done;
    logic [IR_W-1:0] r_ir_sh;
    logic [DR_W-1:0] r_dr_sh;
    logic            r_busy, r_done, r_tms, r_tdi;
    logic [IR_W-1:0] r_ir_out;
    logic [DR_W-1:0] r_dr_out;
    logic            w_rise, w_fall, w_tck;
    logic            w_tms_scan;

    jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_busy),
        .o_tck  (w_tck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // TMS for the next rising edge, chosen from where the mirrored TAP now sits.
    always_comb begin
        w_tms_scan = 1'b1;
        case (r_tap)
            TAP_SEL_DR: w_tms_scan = !r_ir_done;
            TAP_SEL_IR, TAP_CAP_IR,
            TAP_CAP_DR, TAP_UPD_DR: w_tms_scan = 1'b0;
            TAP_SH_IR:  w_tms_scan = (r_cnt == c_ir_last);
            TAP_SH_DR:  w_tms_scan = (r_cnt == c_dr_last);
            default:    w_tms_scan = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl     <= CTL_IDLE;
            r_tap     <= TAP_TLR;
            r_cnt     <= '0;
            r_pre_req <= 1'b1;
            r_ir_done <= 1'b0;
            r_ir_sh   <= '0;
            r_dr_sh   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tms     <= 1'b1;
            r_tdi     <= 1'b0;
            r_ir_out  <= '0;
            r_dr_out  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_ctl == CTL_IDLE) begin
                if (start) begin
                    // Both the preamble and the IR walk open with TMS=1; TCK is low here.
                    r_busy    <= 1'b1;
                    r_tms     <= 1'b1;
                    r_tdi     <= 1'b0;
                    r_cnt     <= '0;
                    r_ir_done <= 1'b0;
                    r_ir_sh   <= ir_in;
                    r_dr_sh   <= dr_in;
                    r_pre_req <= 1'b0;
                    r_ctl     <= (tap_reset || r_pre_req) ? CTL_PRE : CTL_SCAN;
                end
            end else begin
                if (w_rise) begin
                    r_tap <= tap_next(r_tap, r_tms);
                    if (r_tap == TAP_SH_IR) r_ir_out <= {TDO, r_ir_out[IR_W-1:1]};
                    if (r_tap == TAP_SH_DR) r_dr_out <= {TDO, r_dr_out[DR_W-1:1]};
                    if (r_ctl == CTL_PRE) begin
                        if (r_cnt == c_pre_last) begin
                            r_ctl <= CTL_SCAN;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        if (r_tap == TAP_UPD_IR) r_ir_done <= 1'b1;
                        if (r_tap == TAP_UPD_DR) r_ctl <= CTL_END;
                        if ((r_tap == TAP_SH_IR || r_tap == TAP_SH_DR) && !r_tms)
                            r_cnt <= r_cnt + 1'b1;
                        else
                            r_cnt <= '0;
                    end
                end
                if (w_fall) begin
                    r_tdi <= 1'b0;
                    if (r_ctl == CTL_END) begin
                        r_ctl  <= CTL_IDLE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_tms  <= 1'b0;
                    end else if (r_ctl == CTL_PRE) begin
                        r_tms <= (r_cnt != c_pre_last);
                    end else begin
                        r_tms <= w_tms_scan;
                        if (r_tap == TAP_SH_IR) begin
                            r_tdi   <= r_ir_sh[0];
                            r_ir_sh <= r_ir_sh >> 1;
                        end
                        if (r_tap == TAP_SH_DR) begin
                            r_tdi   <= r_dr_sh[0];
                            r_dr_sh <= r_dr_sh >> 1;
                        end
                    end
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign ir_out = r_ir_out;
    assign dr_out = r_dr_out;
    assign TCK    = w_tck;
    assign TMS    = r_tms;
    assign TDI    = r_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_bscan_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtag_bscan_master                                               |
// | Directed + randomized scans against a behavioural TAP target.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_jtag_bscan_master;

    localparam int N      = 16;
    localparam int DR_W   = 3*N+3;
    localparam int IR_W   = 4;
    localparam int E_BASE = IR_W + DR_W + 10;

    localparam int S_TLR = 0,  S_RTI = 1,  S_SDS = 2,  S_CDR = 3;
    localparam int S_SDR = 4,  S_E1D = 5,  S_PDR = 6,  S_E2D = 7;
    localparam int S_UDR = 8,  S_SIS = 9,  S_CIR = 10, S_SIR = 11;
    localparam int S_E1I = 12, S_PIR = 13, S_E2I = 14, S_UIR = 15;

    int on1 [16] = '{S_TLR, S_SDS, S_SIS, S_E1D, S_E1D, S_UDR, S_E2D, S_UDR,
                     S_SDS, S_TLR, S_E1I, S_E1I, S_UIR, S_E2I, S_UIR, S_SDS};
    int on0 [16] = '{S_RTI, S_RTI, S_CDR, S_SDR, S_SDR, S_PDR, S_PDR, S_SDR,
                     S_RTI, S_CIR, S_SIR, S_SIR, S_PIR, S_PIR, S_SIR, S_RTI};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0, tap_reset = 1'b0;
    logic [IR_W-1:0] ir_in = '0;
    logic [DR_W-1:0] dr_in = '0;
    logic            busy, done, TCK, TMS, TDI;
    logic            TDO = 1'b0;
    logic [IR_W-1:0] ir_out;
    logic [DR_W-1:0] dr_out;

    logic            start3 = 1'b0;
    logic            busy3, done3, tck3, tms3, tdi3;
    logic [IR_W-1:0] ir_out3;
    logic [DR_W-1:0] dr_out3;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    jtag_bscan_master #(.N(N), .DR_W(DR_W), .IR_W(IR_W), .DIV(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .tap_reset(tap_reset),
        .ir_in(ir_in), .dr_in(dr_in), .busy(busy), .done(done),
        .ir_out(ir_out), .dr_out(dr_out),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    jtag_bscan_master #(.N(N), .DR_W(DR_W), .IR_W(IR_W), .DIV(3)) u_div3 (
        .clk(clk), .rst(rst), .start(start3), .tap_reset(1'b0),
        .ir_in(ir_in), .dr_in(dr_in), .busy(busy3), .done(done3),
        .ir_out(ir_out3), .dr_out(dr_out3),
        .TCK(tck3), .TMS(tms3), .TDI(tdi3), .TDO(1'b0)
    );

    // Behavioural boundary-scan target hanging off the first master.
    int              tap_st = S_TLR;
    logic [IR_W-1:0] m_ir_cap = '0, m_ir_sr = '0, m_ir_upd = '0;
    logic [DR_W-1:0] m_dr_cap = '0, m_dr_sr = '0, m_dr_upd = '0;
    bit              tms_q[$], tdi_q[$];

    always @(posedge TCK) begin
        case (tap_st)
            S_CIR:   m_ir_sr  <= m_ir_cap;
            S_SIR:   m_ir_sr  <= {TDI, m_ir_sr[IR_W-1:1]};
            S_UIR:   m_ir_upd <= m_ir_sr;
            S_CDR:   m_dr_sr  <= m_dr_cap;
            S_SDR:   m_dr_sr  <= {TDI, m_dr_sr[DR_W-1:1]};
            S_UDR:   m_dr_upd <= m_dr_sr;
            default: ;
        endcase
        tap_st <= TMS ? on1[tap_st] : on0[tap_st];
        tms_q.push_back(TMS);
        tdi_q.push_back(TDI);
    end

    always @(negedge TCK)
        TDO <= (tap_st == S_SIR) ? m_ir_sr[0] : (tap_st == S_SDR) ? m_dr_sr[0] : 1'b0;

    int   done_cnt = 0, hold_viol = 0;
    logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (TCK && p_tck && (TMS !== p_tms || TDI !== p_tdi)) hold_viol <= hold_viol + 1;
        p_tck <= TCK;
        p_tms <= TMS;
        p_tdi <= TDI;
    end

    int   cyc3 = 0, last3 = 0, e3cnt = 0, bad3 = 0;
    logic pt3 = 1'b0, pb3 = 1'b0;
    always @(negedge clk) begin
        cyc3 <= cyc3 + 1;
        pt3  <= tck3;
        pb3  <= busy3;
        if (busy3 && !pb3) begin
            last3 <= cyc3;
        end else if (tck3 !== pt3) begin
            e3cnt <= e3cnt + 1;
            last3 <= cyc3;
            if (cyc3 - last3 != 3) bad3 <= bad3 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input string name, input logic tr,
                           input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [IR_W-1:0] cir, input logic [DR_W-1:0] cdr,
                           input bit pre, input bit poke);
        bit exp_tms[$], exp_tdi[$];
        int base_e, base_d, base_h, n, e_exp, mis_tms, mis_tdi;
        logic [63:0] rnd;
        // Expected pin sequence straight from the scan recipe.
        if (pre) begin
            repeat (5) begin exp_tms.push_back(1); exp_tdi.push_back(0); end
            exp_tms.push_back(0); exp_tdi.push_back(0);
        end
        exp_tms.push_back(1); exp_tms.push_back(1); exp_tms.push_back(0); exp_tms.push_back(0);
        repeat (4) exp_tdi.push_back(0);
        for (int k = 0; k < IR_W; k++) begin
            exp_tms.push_back(k == IR_W - 1); exp_tdi.push_back(ir[k]);
        end
        exp_tms.push_back(1); exp_tdi.push_back(0);
        exp_tms.push_back(1); exp_tms.push_back(0); exp_tms.push_back(0);
        repeat (3) exp_tdi.push_back(0);
        for (int k = 0; k < DR_W; k++) begin
            exp_tms.push_back(k == DR_W - 1); exp_tdi.push_back(dr[k]);
        end
        exp_tms.push_back(1); exp_tms.push_back(0);
        exp_tdi.push_back(0); exp_tdi.push_back(0);
        e_exp = E_BASE + (pre ? 6 : 0);

        m_ir_cap = cir;
        m_dr_cap = cdr;
        base_e = tms_q.size();
        base_d = done_cnt;
        base_h = hold_viol;

        @(negedge clk);
        start = 1'b1; tap_reset = tr; ir_in = ir; dr_in = dr;
        @(negedge clk);
        start = 1'b0; tap_reset = 1'b0;
        rnd = {$urandom(), $urandom()};
        ir_in = rnd[IR_W-1:0]; dr_in = rnd[DR_W-1:0];
        n = 1;
        while (!done && n < 10000) begin
            if (poke && n == 100) begin start = 1'b1; tap_reset = 1'b1; end
            else begin start = 1'b0; tap_reset = 1'b0; end
            @(negedge clk);
            n++;
        end
        start = 1'b0; tap_reset = 1'b0;
        check({name, "_done_latency"}, 64'(n), 64'(2*2*e_exp + 1));
        check({name, "_busy_at_done"}, 64'(busy), 64'(0));
        check({name, "_tck_at_done"}, 64'(TCK), 64'(0));
        repeat (3) @(negedge clk);

        check({name, "_tck_rises"}, 64'(tms_q.size() - base_e), 64'(e_exp));
        mis_tms = 0; mis_tdi = 0;
        for (int i = 0; i < e_exp; i++) begin
            if (base_e + i >= tms_q.size()) begin mis_tms++; mis_tdi++; end
            else begin
                if (tms_q[base_e + i] != exp_tms[i]) mis_tms++;
                if (tdi_q[base_e + i] != exp_tdi[i]) mis_tdi++;
            end
        end
        check({name, "_tms_seq_errs"}, 64'(mis_tms), 64'(0));
        check({name, "_tdi_seq_errs"}, 64'(mis_tdi), 64'(0));
        check({name, "_ir_out"}, 64'(ir_out), 64'(cir));
        check({name, "_dr_out"}, 64'(dr_out), 64'(cdr));
        check({name, "_tap_ir_upd"}, 64'(m_ir_upd), 64'(ir));
        check({name, "_tap_dr_upd"}, 64'(m_dr_upd), 64'(dr));
        check({name, "_done_pulses"}, 64'(done_cnt - base_d), 64'(1));
        check({name, "_hold_viol"}, 64'(hold_viol - base_h), 64'(0));
        check({name, "_idle_tms"}, 64'(TMS), 64'(0));
        check({name, "_tap_parked_rti"}, 64'(tap_st), 64'(S_RTI));
    endtask

    initial begin : main
        logic [63:0] ra, rb, rc;
        logic        tr;
        int          n;

        repeat (3) @(negedge clk);
        check("rst_tck", 64'(TCK), 64'(0));
        check("rst_tms", 64'(TMS), 64'(1));
        check("rst_tdi", 64'(TDI), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ir_out", 64'(ir_out), 64'(0));
        check("rst_dr_out", 64'(dr_out), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn("first", 1'b0, 4'h2, 51'h0_FFFF_0000_AAAA, 4'b0001, 51'h5_5555_AAAA_FFFF, 1'b1, 1'b0);

        ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()}; rc = {$urandom(), $urandom()};
        run_txn("second", 1'b0, ra[IR_W-1:0], rb[DR_W-1:0], rc[IR_W-1:0], rc[DR_W-1:0], 1'b0, 1'b0);

        ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()}; rc = {$urandom(), $urandom()};
        run_txn("forced_tlr", 1'b1, ra[IR_W-1:0], rb[DR_W-1:0], rc[IR_W-1:0], rc[DR_W-1:0], 1'b1, 1'b0);

        ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()}; rc = {$urandom(), $urandom()};
        run_txn("restart_ignored", 1'b0, ra[IR_W-1:0], rb[DR_W-1:0], rc[IR_W-1:0], rc[DR_W-1:0], 1'b0, 1'b1);

        for (int t = 0; t < 2; t++) begin
            ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()}; rc = {$urandom(), $urandom()};
            tr = 1'($urandom_range(0, 1));
            run_txn("random", tr, ra[IR_W-1:0], rb[DR_W-1:0], ra[IR_W+3:4], rc[DR_W-1:0], tr, 1'b0);
        end

        // Pull reset in the middle of the DR shift and confirm the pins let go at once.
        ra = {$urandom(), $urandom()};
        @(negedge clk);
        start = 1'b1; ir_in = ra[IR_W-1:0]; dr_in = ra[DR_W-1:0];
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (tap_st != S_SDR && n < 2000) begin @(negedge clk); n++; end
        check("abort_reached_shift_dr", 64'(tap_st), 64'(S_SDR));
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_tck", 64'(TCK), 64'(0));
        check("abort_tms", 64'(TMS), 64'(1));
        check("abort_tdi", 64'(TDI), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_dr_out", 64'(dr_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        ra = {$urandom(), $urandom()}; rb = {$urandom(), $urandom()}; rc = {$urandom(), $urandom()};
        run_txn("after_abort", 1'b0, ra[IR_W-1:0], rb[DR_W-1:0], rc[IR_W-1:0], rc[DR_W-1:0], 1'b1, 1'b0);

        // Slower divider: every TCK phase must last exactly three clk.
        begin : div3
            int b_e, b_b;
            b_e = e3cnt;
            b_b = bad3;
            @(negedge clk);
            start3 = 1'b1;
            @(negedge clk);
            start3 = 1'b0;
            n = 1;
            while (!done3 && n < 10000) begin @(negedge clk); n++; end
            check("div3_done_latency", 64'(n), 64'(2*3*(E_BASE + 6) + 1));
            check("div3_tck_at_done", 64'(tck3), 64'(0));
            repeat (3) @(negedge clk);
            check("div3_tck_edges", 64'(e3cnt - b_e), 64'(2*(E_BASE + 6)));
            check("div3_phase_len_errs", 64'(bad3 - b_b), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_bscan_master.md
JTAG_BSCAN_MASTER -- requirements
Module: jtag_bscan_master

Interface
REQ-001 SHALL have parameter N, 16, boundary-cell operand width of the target adder.
REQ-002 SHALL have parameter DR_W, 3*N+3 (51), boundary-scan data-register length.
REQ-003 SHALL have parameter IR_W, 4, TAP instruction-register length.
REQ-004 SHALL have parameter DIV, 2, clk cycles per TCK half-period; legal range 1 or more.
REQ-005 SHALL have port clk  in  1  system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  in  1  transaction request; sampled on clk.
REQ-008 SHALL have port tap_reset  in  1  force a Test-Logic-Reset preamble; latched with start.
REQ-009 SHALL have port ir_in  in  IR_W  instruction to shift, LSB first.
REQ-010 SHALL have port dr_in  in  DR_W  boundary data to shift, LSB first.
REQ-011 SHALL have port busy  out  1  transaction in progress.
REQ-012 SHALL have port done  out  1  one-clk pulse at transaction end.
REQ-013 SHALL have port ir_out  out  IR_W  IR bits captured from TDO.
REQ-014 SHALL have port dr_out  out  DR_W  DR bits captured from TDO.
REQ-015 SHALL have ports TCK/TMS/TDI  out  1 each, and TDO  in  1: the JTAG pins.

Function
REQ-016 SHALL accept start only when busy=0 and latch tap_reset, ir_in and dr_in in that cycle; busy SHALL rise the next cycle; start while busy SHALL be ignored.
REQ-017 SHALL generate TCK as clk/(2*DIV), idle low, running only while busy; rise/fall strobes come from the divider.
REQ-018 SHALL change TMS/TDI only on TCK falling edges and sample TDO only on TCK rising edges.
REQ-019 SHALL mirror the 16 IEEE 1149.1 TAP states internally and derive TMS from the mirrored state and a bit counter.
REQ-020 SHALL, if tap_reset or first transaction since rst, emit TMS 1,1,1,1,1,0 (six edges) to reach Run-Test/Idle.
REQ-021 SHALL then emit the IR sequence with TMS 1,1,0,0, then IR_W shift edges with TMS=0 except the last (TMS=1, Exit1-IR), then 1 (Update-IR).
REQ-022 SHALL then emit the DR sequence with TMS 1,0,0, then DR_W shift edges with the last TMS=1, then 1 (Update-DR), then 0 (Run-Test/Idle).
REQ-023 SHALL total E = IR_W+DR_W+10 TCK rising edges per transaction, plus 6 with the preamble (65/71 at defaults).
REQ-024 SHALL drive TDI with ir/dr bit k during shift edge k (k=0 first) and 0 outside Shift states.
REQ-025 SHALL shift the TDO sample of each shift edge into ir_out/dr_out at bit k; bits are valid when done pulses and held until the next accepted start.
REQ-026 SHALL assert done for exactly one clk and drop busy in the same cycle, 2*DIV*E+1 clk after the start cycle, with TCK low.
REQ-027 SHALL hold TMS=0 (TAP parked in Run-Test/Idle) while idle after the first completed transaction.

Reset
REQ-028 SHALL, on rst (async, any time incl. mid-shift), immediately force TCK=0, TMS=1, TDI=0, busy=0, done=0, ir_out=0, dr_out=0, divider=0, mirror=Test-Logic-Reset.
REQ-029 SHALL set a preamble-required flag on rst so the next transaction always performs REQ-020.

Structure
REQ-030 SHALL place the TAP state enumeration and the default N/IR_W/DIV constants in shared package jtag_pkg.
REQ-031 SHALL implement the TCK divider and rise/fall strobes as sub-module jtag_tck_gen.

Verification
REQ-032 SHALL verify: after rst, start with ir_in=4'h2, dr_in=51'h0_FFFF_0000_AAAA -> 71 TCK rises, first six TMS 1,1,1,1,1,0, one done pulse.
REQ-033 SHALL verify: bench TAP model capturing IR=4'b0001 and DR=51'h5_5555_AAAA_FFFF -> ir_out=4'b0001, dr_out=51'h5_5555_AAAA_FFFF, and the model's updated DR equals dr_in.
REQ-034 SHALL verify: second start with tap_reset=0 -> exactly 65 TCK rises and no five-ones preamble.
REQ-035 SHALL verify: start pulsed again mid-transaction -> ignored, single done, latched operands unchanged.
REQ-036 SHALL verify: rst asserted during Shift-DR -> TCK=0, TMS=1, busy=0 with no clk edge; next start emits 71 edges.
REQ-037 SHALL verify: DIV=3 -> TCK high and low each exactly 3 clk, with done at 2*3*E+1 clk after start.
